// File: rtl/program_encoder.sv
// Packs per-field instruction requests into 16-bit control-unit words and streams them,
// through a small FIFO, into program memory at auto-incrementing addresses.
module program_encoder #(
    parameter int ADDR_W     = 15,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_kind,
    input  logic [15:0]       in_imm,
    input  logic [2:0]        in_dest,
    input  logic [1:0]        in_x_sel,
    input  logic [1:0]        in_y_sel,
    input  logic              in_zero_x,
    input  logic              in_zero_y,
    input  logic              in_negate,
    input  logic [1:0]        in_opcode,
    input  logic [2:0]        in_jump,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_stall,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_written,
    output logic              err_imm,
    output logic              err_overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]     FULL_CNT = FIFO_DEPTH[PW:0];
    localparam logic [PW:0]     CNT_ONE  = 1;
    localparam logic [PW-1:0]   PTR_ONE  = 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W:0]   WW_ONE   = 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [15:0]       fifo [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       count;
    logic [ADDR_W-1:0] addr;        // address of the next memory write
    logic              exhausted;   // last address already written
    logic [15:0]       word;
    logic              fifo_full, fifo_empty, accept, bad_imm, push, pop, complete, start_ok;
    logic              load_exh;
    logic [ADDR_W-1:0] load_addr;

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    assign in_ready   = (state == RUN) && !fifo_full;
    assign busy       = (state == RUN) || (state == DRAIN);
    assign accept     = in_valid && in_ready;
    assign bad_imm    = in_kind && in_imm[15];
    assign push       = accept && !bad_imm;
    assign complete   = mem_we && !mem_stall;
    assign pop        = !fifo_empty && (!mem_we || !mem_stall);
    assign start_ok   = start && ((state == IDLE) || (state == DONE));

    // A word popped on the same edge a write completes must see the post-completion address.
    assign load_exh  = exhausted || (complete && (addr == '1));
    assign load_addr = complete ? addr + ADDR_ONE : addr;

    always_comb begin
        if (in_kind)
            word = {1'b1, in_imm[14:0]};
        else
            word = {1'b0, in_dest, in_y_sel, in_x_sel, in_zero_x, in_zero_y,
                    in_negate, in_opcode, in_jump};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (flush) state_nxt = DRAIN;
            DRAIN:   if (fifo_empty && !mem_we) state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= word;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            addr          <= '0;
            exhausted     <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            done          <= 1'b0;
            words_written <= '0;
            err_imm       <= 1'b0;
            err_overflow  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == DRAIN) && (state_nxt == DONE);

            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)      count <= count + CNT_ONE;
            else if (pop && !push) count <= count - CNT_ONE;

            if (accept && bad_imm) err_imm <= 1'b1;

            if (complete) begin
                words_written <= words_written + WW_ONE;
                if (addr == '1) exhausted <= 1'b1;
                else            addr      <= addr + ADDR_ONE;
            end

            if (pop) begin
                if (load_exh) begin
                    mem_we       <= 1'b0;
                    err_overflow <= 1'b1;
                end else begin
                    mem_we    <= 1'b1;
                    mem_addr  <= load_addr;
                    mem_wdata <= fifo[rd_ptr];
                end
            end else if (complete) begin
                mem_we <= 1'b0;
            end

            // Start only happens with nothing in flight, so it never collides with a completion.
            if (start_ok) begin
                addr          <= base_addr;
                exhausted     <= 1'b0;
                words_written <= '0;
                err_imm       <= 1'b0;
                err_overflow  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_program_encoder.sv
// Scoreboard bench for program_encoder: a 15-bit-address instance for the main run and a
// 4-bit-address instance for address exhaustion, selected by sel4.
module tb_program_encoder;
    logic        clk = 0;
    logic        reset = 1;
    logic        sel4 = 0;
    logic        start = 0, flush = 0, in_valid = 0, mem_stall = 0;
    logic [14:0] base_addr = '0;
    logic        in_kind = 0;
    logic [15:0] in_imm = '0;
    logic [2:0]  in_dest = '0, in_jump = '0;
    logic [1:0]  in_x_sel = '0, in_y_sel = '0, in_opcode = '0;
    logic        in_zero_x = 0, in_zero_y = 0, in_negate = 0;

    logic        rdy_a, we_a, busy_a, done_a, ei_a, eo_a;
    logic [14:0] addr_a;
    logic [15:0] wd_a, ww_a;
    logic        rdy_b, we_b, busy_b, done_b, ei_b, eo_b;
    logic [3:0]  addr_b;
    logic [15:0] wd_b;
    logic [4:0]  ww_b;
    logic        rst_a, rst_b;

    assign rst_a = reset | sel4;
    assign rst_b = reset | ~sel4;

    wire        rdy   = sel4 ? rdy_b  : rdy_a;
    wire        we    = sel4 ? we_b   : we_a;
    wire [14:0] maddr = sel4 ? {11'd0, addr_b} : addr_a;
    wire [15:0] wdata = sel4 ? wd_b   : wd_a;
    wire        bsy   = sel4 ? busy_b : busy_a;
    wire        dn    = sel4 ? done_b : done_a;
    wire [15:0] ww    = sel4 ? {11'd0, ww_b} : ww_a;
    wire        e_imm = sel4 ? ei_b   : ei_a;
    wire        e_ovf = sel4 ? eo_b   : eo_a;

    program_encoder #(.ADDR_W(15), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(rst_a), .start(start), .base_addr(base_addr), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy_a), .in_kind(in_kind), .in_imm(in_imm),
        .in_dest(in_dest), .in_x_sel(in_x_sel), .in_y_sel(in_y_sel), .in_zero_x(in_zero_x),
        .in_zero_y(in_zero_y), .in_negate(in_negate), .in_opcode(in_opcode), .in_jump(in_jump),
        .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wd_a), .mem_stall(mem_stall),
        .busy(busy_a), .done(done_a), .words_written(ww_a), .err_imm(ei_a), .err_overflow(eo_a));

    program_encoder #(.ADDR_W(4), .FIFO_DEPTH(4)) dut4 (
        .clk(clk), .reset(rst_b), .start(start), .base_addr(base_addr[3:0]), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy_b), .in_kind(in_kind), .in_imm(in_imm),
        .in_dest(in_dest), .in_x_sel(in_x_sel), .in_y_sel(in_y_sel), .in_zero_x(in_zero_x),
        .in_zero_y(in_zero_y), .in_negate(in_negate), .in_opcode(in_opcode), .in_jump(in_jump),
        .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wd_b), .mem_stall(mem_stall),
        .busy(busy_b), .done(done_b), .words_written(ww_b), .err_imm(ei_b), .err_overflow(eo_b));

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0, n_acc = 0, n_done = 0;
    logic [30:0] exp_q [$];   // {addr, data}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every completing write against the scoreboard and watches stall holds.
    logic        hold_prev = 0;
    logic [14:0] prev_addr;
    logic [15:0] prev_data;
    always @(negedge clk) begin
        if (reset) begin
            hold_prev = 0;
        end else begin
            if (hold_prev) begin
                check("stall_hold_we", {31'd0, we}, 32'd1);
                check("stall_hold_addr", {17'd0, maddr}, {17'd0, prev_addr});
                check("stall_hold_data", {16'd0, wdata}, {16'd0, prev_data});
            end
            hold_prev = we & mem_stall;
            prev_addr = maddr;
            prev_data = wdata;
            if (dn) n_done++;
            if (we && !mem_stall) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {1'b0, maddr, wdata}, 32'hFFFF_FFFF);
                end else begin
                    logic [30:0] e;
                    e = exp_q.pop_front();
                    check("write_addr", {17'd0, maddr}, {17'd0, e[30:16]});
                    check("write_data", {16'd0, wdata}, {16'd0, e[15:0]});
                end
            end
        end
    end

    task automatic expect_wr(input logic [14:0] a, input logic [15:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic send(input logic kind, input logic [15:0] imm, input logic [2:0] dest,
                        input logic [1:0] x, input logic [1:0] y, input logic zx, input logic zy,
                        input logic neg, input logic [1:0] op, input logic [2:0] jmp);
        int t = 0;
        in_kind = kind; in_imm = imm; in_dest = dest; in_x_sel = x; in_y_sel = y;
        in_zero_x = zx; in_zero_y = zy; in_negate = neg; in_opcode = op; in_jump = jmp;
        in_valid = 1;
        @(negedge clk);
        while (!rdy && t < 100) begin @(negedge clk); t++; end
        if (!rdy) check("handshake_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 0;
        n_acc++;
    endtask

    task automatic send_a(input logic [15:0] imm);
        send(1'b1, imm, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0);
    endtask

    task automatic pulse_start(input logic [14:0] b);
        base_addr = b; start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic pulse_flush();
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || we) && t < 300) begin @(negedge clk); t++; end
        if (t >= 300) check("drain_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_done();
        int t = 0;
        while (n_done == 0 && t < 300) begin @(posedge clk); #1; t++; end
        if (n_done == 0) check("done_timeout", 32'd0, 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, rdy}, 0);
        check("rst_we", {31'd0, we}, 0);
        check("rst_addr", {17'd0, maddr}, 0);
        check("rst_data", {16'd0, wdata}, 0);
        check("rst_done", {31'd0, dn}, 0);
        check("rst_ww", {16'd0, ww}, 0);
        check("rst_errs", {30'd0, e_imm, e_ovf}, 0);
        reset = 0;
        @(posedge clk); #1;

        // Basic C encode and two-cycle latency.
        pulse_start(15'h0010);
        check("busy_run", {31'd0, bsy}, 1);
        expect_wr(15'h0010, 16'h2400);
        send(1'b0, 16'h0, 3'b010, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0);
        check("lat_we_edgeN", {31'd0, we}, 0);
        @(posedge clk); #1;
        check("lat_we_edgeN1", {31'd0, we}, 1);
        check("lat_addr", {17'd0, maddr}, 32'h10);
        check("lat_data", {16'd0, wdata}, 32'h2400);
        wait_drain();

        // A then C back to back.
        expect_wr(15'h0011, 16'h9234);
        expect_wr(15'h0012, 16'h0007);
        send_a(16'h1234);
        send(1'b0, 16'h0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd7);
        wait_drain();

        // Out-of-range immediate is swallowed; the address does not advance.
        send_a(16'h8000);
        expect_wr(15'h0013, 16'h7BB5);
        send(1'b0, 16'h0, 3'b111, 2'd3, 2'd2, 1'b1, 1'b0, 1'b1, 2'd2, 3'd5);
        wait_drain();
        check("err_imm_set", {31'd0, e_imm}, 1);
        check("err_ovf_clear", {31'd0, e_ovf}, 0);

        // Stall with FIFO_DEPTH+2 requests.
        mem_stall = 1;
        n_acc = 0;
        for (int i = 1; i <= 6; i++) expect_wr(15'h0013 + 15'(i), 16'h8000 + 16'(i));
        fork
            for (int i = 1; i <= 6; i++) send_a(16'(i));
            begin
                int t = 0;
                @(negedge clk);
                while (rdy && t < 100) begin @(negedge clk); t++; end
                check("full_accepts", n_acc, 5);
                check("full_ready", {31'd0, rdy}, 0);
                check("full_we", {31'd0, we}, 1);
                check("full_addr", {17'd0, maddr}, 32'h14);
                repeat (5) @(posedge clk);
                #1 mem_stall = 0;
            end
        join
        wait_drain();
        check("ww_after_stall", {16'd0, ww}, 10);

        n_done = 0;
        pulse_flush();
        wait_done();
        check("done_empty_flush", n_done, 1);
        check("idle_after_done", {31'd0, bsy}, 0);

        // New run clears counters and errors; flush with three words queued.
        pulse_start(15'h0020);
        check("start_ww_clr", {16'd0, ww}, 0);
        check("start_err_clr", {31'd0, e_imm}, 0);
        mem_stall = 1;
        expect_wr(15'h0020, 16'h8100);
        expect_wr(15'h0021, 16'h8200);
        expect_wr(15'h0022, 16'h8300);
        send_a(16'h0100);
        send_a(16'h0200);
        send_a(16'h0300);
        n_done = 0;
        pulse_flush();
        check("drain_busy", {31'd0, bsy}, 1);
        check("drain_ready", {31'd0, rdy}, 0);
        mem_stall = 0;
        wait_done();
        check("flush_done_once", n_done, 1);
        check("flush_ww", {16'd0, ww}, 3);

        // Reset in the middle of DRAIN.
        pulse_start(15'h0030);
        send_a(16'h8000);
        expect_wr(15'h0030, 16'h8005);
        send_a(16'h0005);
        wait_drain();
        mem_stall = 1;
        expect_wr(15'h0031, 16'h8006);
        expect_wr(15'h0032, 16'h8007);
        send_a(16'h0006);
        send_a(16'h0007);
        pulse_flush();
        check("pre_rst_busy", {31'd0, bsy}, 1);
        check("pre_rst_ww", {16'd0, ww}, 1);
        reset = 1;
        #1;
        check("midrst_we", {31'd0, we}, 0);
        check("midrst_addr", {17'd0, maddr}, 0);
        check("midrst_data", {16'd0, wdata}, 0);
        check("midrst_busy_ready", {30'd0, bsy, rdy}, 0);
        check("midrst_ww", {16'd0, ww}, 0);
        check("midrst_errs", {30'd0, e_imm, e_ovf}, 0);
        exp_q.delete();
        mem_stall = 0;
        @(posedge clk); #1;
        reset = 0;

        // Address exhaustion on the 4-bit instance.
        sel4 = 1;
        @(posedge clk); #1;
        pulse_start(15'h000E);
        expect_wr(15'h000E, 16'h8011);
        expect_wr(15'h000F, 16'h8022);
        send_a(16'h0011);
        send_a(16'h0022);
        send_a(16'h0033);
        wait_drain();
        repeat (2) @(posedge clk);
        #1;
        check("ovf_err", {31'd0, e_ovf}, 1);
        check("ovf_ww", {16'd0, ww}, 2);
        check("ovf_we_low", {31'd0, we}, 0);
        n_done = 0;
        pulse_flush();
        wait_done();
        check("ovf_done", n_done, 1);
        check("ovf_leftover", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
